// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter: shares one single-ported memory between fetch and load/store,
// one transaction in flight. Optional fairness: MEM_PORT_ARB_FAIR_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
   parameter int MAX_WAIT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [1:0]  d_width,
   input  logic        d_uns,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [3:0]  m_be,
   output logic [31:0] m_wdata,
   input  logic        m_ready,
   input  logic        m_rvalid,
   input  logic [31:0] m_rdata
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_ISSUE = 2'd1;
   localparam logic [1:0] c_WAIT  = 2'd2;
   localparam logic [1:0] c_RESP  = 2'd3;

   localparam logic [1:0] c_W_BYTE = 2'b00;
   localparam logic [1:0] c_W_HALF = 2'b01;
   localparam logic [1:0] c_W_WORD = 2'b10;

   logic [1:0]  r_state;
   logic        r_own_d;
   logic        r_we;
   logic        r_uns;
   logic [1:0]  r_width;
   logic [1:0]  r_lane;
   logic [29:0] r_waddr;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;

   logic        w_idle;
   logic        w_fetch_prio;
   logic        w_d_win;
   logic        w_i_win;
   logic        w_misalign;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_lane_word;
   logic [31:0] w_load_data;
   logic        w_unused_ok;

   assign w_unused_ok = ^if_addr[1:0];

   // Grants are suppressed while reset is held so every output reads 0.
   assign w_idle = rst && (r_state == c_IDLE);

`ifdef MEM_PORT_ARB_FAIR_EN
   localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);
   logic [3:0] r_wait_cnt;

   assign w_fetch_prio = if_req && (r_wait_cnt == c_MAX_WAIT);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wait_cnt <= 4'd0;
      end else if (if_gnt) begin
         r_wait_cnt <= 4'd0;
      end else if (d_gnt && if_req && (r_wait_cnt != c_MAX_WAIT)) begin
         r_wait_cnt <= r_wait_cnt + 4'd1;
      end
   end
`else
   localparam int c_unused_max_wait = MAX_WAIT;
   assign w_fetch_prio = 1'b0;
`endif

   assign w_d_win = d_req && !w_fetch_prio;
   assign w_i_win = if_req && !w_d_win;
   assign d_gnt   = w_idle && w_d_win;
   assign if_gnt  = w_idle && w_i_win;
   assign d_err   = d_gnt && w_misalign;

   always_comb begin
      w_misalign = 1'b0;
      case (d_width)
         c_W_BYTE: w_misalign = 1'b0;
         c_W_HALF: w_misalign = d_addr[0];
         c_W_WORD: w_misalign = (d_addr[1:0] != 2'b00);
         default:  w_misalign = 1'b1;
      endcase
   end

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = d_wdata;
      case (d_width)
         c_W_BYTE: begin
            w_be    = 4'b0001 << d_addr[1:0];
            w_wdata = {4{d_wdata[7:0]}};
         end
         c_W_HALF: begin
            w_be    = 4'b0011 << d_addr[1:0];
            w_wdata = {2{d_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign w_lane_word = m_rdata >> {r_lane, 3'b000};

   always_comb begin
      w_load_data = m_rdata;
      case (r_width)
         c_W_BYTE: w_load_data = r_uns ? {24'b0, w_lane_word[7:0]}
                                       : {{24{w_lane_word[7]}}, w_lane_word[7:0]};
         c_W_HALF: w_load_data = r_uns ? {16'b0, w_lane_word[15:0]}
                                       : {{16{w_lane_word[15]}}, w_lane_word[15:0]};
         default:  w_load_data = m_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= c_IDLE;
         r_own_d <= 1'b0;
         r_we    <= 1'b0;
         r_uns   <= 1'b0;
         r_width <= 2'b00;
         r_lane  <= 2'b00;
         r_waddr <= 30'd0;
         r_be    <= 4'd0;
         r_wdata <= 32'd0;
         r_rdata <= 32'd0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (if_gnt) begin
                  r_own_d <= 1'b0;
                  r_we    <= 1'b0;
                  r_uns   <= 1'b0;
                  r_width <= c_W_WORD;
                  r_lane  <= 2'b00;
                  r_waddr <= if_addr[31:2];
                  r_be    <= 4'b1111;
                  r_wdata <= 32'd0;
                  r_state <= c_ISSUE;
               end else if (d_gnt && !w_misalign) begin
                  r_own_d <= 1'b1;
                  r_we    <= d_we;
                  r_uns   <= d_uns;
                  r_width <= d_width;
                  r_lane  <= d_addr[1:0];
                  r_waddr <= d_addr[31:2];
                  r_be    <= w_be;
                  r_wdata <= w_wdata;
                  r_state <= c_ISSUE;
               end
            end
            c_ISSUE: begin
               if (m_ready) begin
                  if (r_we) begin
                     r_rdata <= 32'd0;
                     r_state <= c_RESP;
                  end else if (m_rvalid) begin
                     r_rdata <= w_load_data;
                     r_state <= c_RESP;
                  end else begin
                     r_state <= c_WAIT;
                  end
               end
            end
            c_WAIT: begin
               if (m_rvalid) begin
                  r_rdata <= w_load_data;
                  r_state <= c_RESP;
               end
            end
            c_RESP:  r_state <= c_IDLE;
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign m_req     = (r_state == c_ISSUE);
   assign m_we      = m_req && r_we;
   assign m_addr    = m_req ? {r_waddr, 2'b00} : 32'd0;
   assign m_be      = m_req ? r_be : 4'd0;
   assign m_wdata   = m_req ? r_wdata : 32'd0;

   assign if_rvalid = (r_state == c_RESP) && !r_own_d;
   assign d_rvalid  = (r_state == c_RESP) && r_own_d;
   assign if_rdata  = if_rvalid ? r_rdata : 32'd0;
   assign d_rdata   = d_rvalid ? r_rdata : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter: directed bench with a response scoreboard and a small
// memory model of configurable read latency and acceptance stall.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [1:0]  d_width;
   logic        d_uns;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [3:0]  m_be;
   logic [31:0] m_wdata;
   logic        m_ready;
   logic        m_rvalid;
   logic [31:0] m_rdata;

   logic        mem_ready_en;
   int          mem_lat;
   logic [31:0] mem_word;
   logic [3:0]  rv_cnt = 4'd0;

   typedef struct packed {
      logic        is_d;
      logic [31:0] data;
   } exp_t;
   exp_t q[$];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MAX_WAIT(2)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_width(d_width),
      .d_uns(d_uns), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
      .d_rdata(d_rdata), .d_err(d_err),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be),
      .m_wdata(m_wdata), .m_ready(m_ready), .m_rvalid(m_rvalid),
      .m_rdata(m_rdata)
   );

   // Memory model: mem_lat = 0 returns data in the accepting cycle.
   assign m_ready  = m_req && mem_ready_en;
   assign m_rvalid = (rv_cnt == 4'd1) || ((mem_lat == 0) && m_req && m_ready && !m_we);
   assign m_rdata  = mem_word;

   always @(posedge clk) begin
      if (m_req && m_ready && !m_we && (mem_lat != 0))
         rv_cnt <= 4'(mem_lat);
      else if (rv_cnt != 4'd0)
         rv_cnt <= rv_cnt - 4'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (if_rvalid || d_rvalid) begin
         vectors++;
         assert (q.size() != 0) else begin
            miscompares++;
            $error("FAIL unexpected_rvalid observed=if%b/d%b expected=none", if_rvalid, d_rvalid);
         end
         if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rv_both", {31'b0, if_rvalid & d_rvalid}, 32'd0);
            chk("rv_owner", {31'b0, d_rvalid}, {31'b0, e.is_d});
            chk("rv_data", e.is_d ? d_rdata : if_rdata, e.data);
         end
      end
   end

   task automatic drain(input string tag);
      int n = 0;
      while (q.size() != 0 && n < 30) begin
         @(negedge clk);
         #2;
         n++;
      end
      chk(tag, 32'(q.size()), 32'd0);
   endtask

   task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] w,
                          input logic u, input logic [31:0] mw,
                          input logic [3:0] be_exp, input logic [31:0] exp);
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = a; d_width = w; d_uns = u; mem_word = mw;
      #1;
      chk({tag, "_gnt"}, {31'b0, d_gnt}, 32'd1);
      chk({tag, "_err"}, {31'b0, d_err}, 32'd0);
      q.push_back({1'b1, exp});
      @(negedge clk);
      d_req = 1'b0; d_addr = 32'hFFFF_FFFF;
      #1;
      chk({tag, "_be"}, {28'b0, m_be}, {28'b0, be_exp});
      chk({tag, "_addr"}, m_addr, {a[31:2], 2'b00});
      drain({tag, "_drain"});
   endtask

   task automatic do_store(input string tag, input logic [31:0] a, input logic [1:0] w,
                           input logic [31:0] wd, input logic [3:0] be_exp,
                           input logic [31:0] wd_exp);
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = a; d_width = w; d_wdata = wd;
      #1;
      chk({tag, "_gnt"}, {31'b0, d_gnt}, 32'd1);
      q.push_back({1'b1, 32'd0});
      @(negedge clk);
      d_req = 1'b0; d_wdata = 32'h0; d_addr = 32'h0;
      #1;
      chk({tag, "_we"}, {31'b0, m_we}, 32'd1);
      chk({tag, "_be"}, {28'b0, m_be}, {28'b0, be_exp});
      chk({tag, "_wdata"}, m_wdata, wd_exp);
      @(negedge clk);
      #1;
      chk({tag, "_rv_t2"}, {31'b0, d_rvalid}, 32'd1);
      drain({tag, "_drain"});
   endtask

   task automatic do_fetch(input string tag, input logic [31:0] a, input logic [31:0] mw);
      @(negedge clk);
      if_req = 1'b1; if_addr = a; mem_word = mw;
      #1;
      chk({tag, "_gnt"}, {31'b0, if_gnt}, 32'd1);
      q.push_back({1'b0, mw});
      @(negedge clk);
      if_req = 1'b0;
      drain({tag, "_drain"});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] order;
      logic [5:0] order_exp;
      int ng;

      rst = 1'b0; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
      d_addr = 32'h0; d_width = 2'b00; d_uns = 1'b0; d_wdata = 32'h0;
      mem_ready_en = 1'b1; mem_lat = 1; mem_word = 32'h0;

      // Reset state, including grant suppression while reset is held
      repeat (3) @(negedge clk);
      if_req = 1'b1; d_req = 1'b1;
      #1;
      chk("rst_gnt", {30'b0, if_gnt, d_gnt}, 32'd0);
      chk("rst_m_req", {31'b0, m_req}, 32'd0);
      chk("rst_m_addr", m_addr, 32'd0);
      chk("rst_m_be", {28'b0, m_be}, 32'd0);
      chk("rst_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'd0);
      chk("rst_rdata", if_rdata | d_rdata, 32'd0);
      chk("rst_err", {31'b0, d_err}, 32'd0);
      if_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // Fetch with exact cycle timing
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h0040_0004; mem_word = 32'h0050_0093;
      #1;
      chk("f_gnt", {31'b0, if_gnt}, 32'd1);
      chk("f_dgnt", {31'b0, d_gnt}, 32'd0);
      q.push_back({1'b0, 32'h0050_0093});
      @(negedge clk);
      if_req = 1'b0; if_addr = 32'hDEAD_BEEC;
      #1;
      chk("f_m_req", {31'b0, m_req}, 32'd1);
      chk("f_m_addr", m_addr, 32'h0040_0004);
      chk("f_m_we", {31'b0, m_we}, 32'd0);
      chk("f_m_be", {28'b0, m_be}, 32'hF);
      @(negedge clk);
      #1;
      chk("f_t2_rv", {31'b0, if_rvalid}, 32'd0);
      @(negedge clk);
      #1;
      chk("f_t3_rv", {31'b0, if_rvalid}, 32'd1);
      drain("f_drain");

      // Loads: lane select and extension
      do_load("lb_s", 32'h1001_0003, 2'b00, 1'b0, 32'h80FF_0000, 4'b1000, 32'hFFFF_FF80);
      do_load("lb_u", 32'h1001_0003, 2'b00, 1'b1, 32'h80FF_0000, 4'b1000, 32'h0000_0080);
      do_load("lh_s", 32'h1001_0002, 2'b01, 1'b0, 32'h80FF_0000, 4'b1100, 32'hFFFF_80FF);
      do_load("lh_u", 32'h1001_0000, 2'b01, 1'b1, 32'h1234_F00D, 4'b0011, 32'h0000_F00D);
      do_load("lb_1", 32'h1001_0001, 2'b00, 1'b0, 32'h0000_7F00, 4'b0010, 32'h0000_007F);
      do_load("lw",   32'h1001_0004, 2'b10, 1'b0, 32'h80FF_0000, 4'b1111, 32'h80FF_0000);

      // Stores: lane enables and replication
      do_store("sh", 32'h1001_0002, 2'b01, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
      do_store("sb", 32'h1001_0001, 2'b00, 32'h0000_005A, 4'b0010, 32'h5A5A_5A5A);
      do_store("sw", 32'h1001_0008, 2'b10, 32'hCAFE_BABE, 4'b1111, 32'hCAFE_BABE);

      // Misaligned word store: error in the grant cycle, FSM stays in IDLE
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0001; d_width = 2'b10;
      #1;
      chk("mis_gnt", {31'b0, d_gnt}, 32'd1);
      chk("mis_err", {31'b0, d_err}, 32'd1);
      @(negedge clk);
      d_req = 1'b0; if_req = 1'b1; if_addr = 32'h0040_0008; mem_word = 32'h0000_0013;
      #1;
      chk("mis_no_mreq", {31'b0, m_req}, 32'd0);
      chk("mis_err_pulse", {31'b0, d_err}, 32'd0);
      chk("mis_idle_gnt", {31'b0, if_gnt}, 32'd1);
      q.push_back({1'b0, 32'h0000_0013});
      @(negedge clk);
      if_req = 1'b0;
      drain("mis_drain");

      // Illegal width 11
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0000; d_width = 2'b11;
      #1;
      chk("w11_err", {31'b0, d_err}, 32'd1);
      @(negedge clk);
      d_req = 1'b0;
      #1;
      chk("w11_no_mreq", {31'b0, m_req}, 32'd0);
      repeat (3) @(negedge clk);

      // Stall: m_* hold while m_ready is low
      mem_ready_en = 1'b0;
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h0040_0010; mem_word = 32'h0000_0033;
      #1;
      chk("st_gnt", {31'b0, if_gnt}, 32'd1);
      q.push_back({1'b0, 32'h0000_0033});
      @(negedge clk);
      if_req = 1'b0; if_addr = 32'h0BAD_0000;
      #1;
      chk("st_addr1", m_addr, 32'h0040_0010);
      @(negedge clk);
      #1;
      chk("st_req2", {31'b0, m_req}, 32'd1);
      chk("st_addr2", m_addr, 32'h0040_0010);
      mem_ready_en = 1'b1;
      @(negedge clk);
      #1;
      chk("st_rv_early", {31'b0, if_rvalid}, 32'd0);
      @(negedge clk);
      #1;
      chk("st_rv", {31'b0, if_rvalid}, 32'd1);
      drain("st_drain");

      // m_ready and m_rvalid in the same cycle
      mem_lat = 0;
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0004; d_width = 2'b10; d_uns = 1'b0;
      mem_word = 32'hCAFE_F00D;
      #1;
      chk("z_gnt", {31'b0, d_gnt}, 32'd1);
      q.push_back({1'b1, 32'hCAFE_F00D});
      @(negedge clk);
      d_req = 1'b0;
      @(negedge clk);
      #1;
      chk("z_rv_t2", {31'b0, d_rvalid}, 32'd1);
      drain("z_drain");
      mem_lat = 1;

      // Continuous fetch and data requests: grant order
      order = 6'b0;
      ng = 0;
`ifdef MEM_PORT_ARB_FAIR_EN
      order_exp = 6'b110110;
`else
      order_exp = 6'b111111;
`endif
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h0040_000C;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0008; d_width = 2'b10; d_uns = 1'b1;
      mem_word = 32'h1122_3344;
      for (int c = 0; c < 100 && ng < 6; c++) begin
         if (c != 0) @(negedge clk);
         #1;
         if (d_gnt) begin
            order = {order[4:0], 1'b1};
            ng++;
            q.push_back({1'b1, 32'h1122_3344});
         end else if (if_gnt) begin
            order = {order[4:0], 1'b0};
            ng++;
            q.push_back({1'b0, 32'h1122_3344});
         end
      end
      chk("ord_count", 32'(ng), 32'd6);
      chk("ord_seq", {26'b0, order}, {26'b0, order_exp});
      @(negedge clk);
      if_req = 1'b0; d_req = 1'b0;
      drain("ord_drain");

      // Reset during WAIT with a late m_rvalid
      mem_lat = 3;
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0000; d_width = 2'b10;
      mem_word = 32'h55AA_55AA;
      #1;
      chk("ab_gnt", {31'b0, d_gnt}, 32'd1);
      @(negedge clk);
      d_req = 1'b0;
      #1;
      chk("ab_mreq", {31'b0, m_req}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("ab_m_req", {31'b0, m_req}, 32'd0);
      chk("ab_m_addr", m_addr, 32'd0);
      chk("ab_m_be", {28'b0, m_be}, 32'd0);
      chk("ab_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'd0);
      chk("ab_rdata", if_rdata | d_rdata, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("ab_late_rv", {30'b0, if_rvalid, d_rvalid}, 32'd0);
      @(negedge clk);
      #1;
      chk("ab_after_rv", {30'b0, if_rvalid, d_rvalid}, 32'd0);
      mem_lat = 1;
      do_fetch("ab_next", 32'h0040_0020, 32'h0000_0073);

      repeat (3) @(negedge clk);
      chk("final_queue", 32'(q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the core's instruction-fetch port and load/store port onto one shared single-ported memory, with at most one transaction in flight. Converts load/store width and extension requests into word-aligned memory accesses:
- per-byte lane enables for writes;
- lane replication of store data;
- lane selection and extension of load data.

It sits between the fetch/MA stages of the five-stage core and the unified backing memory.

## Interface
Parameters:
- MAX_WAIT, 2: number of consecutive data-side wins allowed while fetch is waiting. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset. Synchronous, active-low.
- if_req  in  1  fetch request. Held until if_gnt.
- if_addr  in  32  fetch address. Word aligned; bits [1:0] ignored.
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  32  fetched word
- d_req  in  1  data request. Held until d_gnt.
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  byte address
- d_width  in  2  00 byte, 01 half, 10 word; 11 is illegal
- d_uns  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- d_wdata  in  32  store data, right-aligned
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle completion pulse, loads and stores
- d_rdata  out  32  extended load data; 0 for stores
- d_err  out  1  one-cycle pulse for a misaligned or illegal-width request
- m_req  out  1  memory request. Held until m_ready.
- m_we  out  1  memory write
- m_addr  out  32  word address, {addr[31:2], 2'b00}
- m_be  out  4  byte enables
- m_wdata  out  32  lane-replicated store data
- m_ready  in  1  memory accepts m_req this cycle
- m_rvalid  in  1  read data valid, any cycle after acceptance
- m_rdata  in  32  read word

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Arbitrate the current requests. Assert if_gnt or d_gnt combinationally for the winner.
  - Latch the winner's address and attributes at the edge.
  - Go to ISSUE. Exception: a d_err request goes straight back to IDLE.
  - m_rvalid is ignored in IDLE.
- **ISSUE**
  - m_req = 1 with the latched fields.
  - On m_ready: a write goes to RESP; a read goes to WAIT.
  - If m_ready and m_rvalid occur in the same cycle, capture the data and go to RESP.
- **WAIT**: on m_rvalid, capture m_rdata and go to RESP.
- **RESP**
  - Pulse the owner's rvalid. rdata is registered.
  - Go to IDLE.
- **Priority**
  - Data wins over fetch by default.
  - wait_cnt increments on each data grant made while if_req=1. It saturates at MAX_WAIT.
  - When wait_cnt == MAX_WAIT and if_req=1, fetch wins. wait_cnt clears on any fetch grant.
- **Alignment**
  - Half-word with addr[0]=1, word with addr[1:0]!=0, or width 11 → d_err.
  - An errored request gets d_gnt and d_err in the same cycle, issues no memory access, and produces no d_rvalid.
- **Byte enables**
  - Byte: 4'b0001 << addr[1:0].
  - Half: 4'b0011 << addr[1:0].
  - Word: 4'b1111.
  - Fetch and loads also drive these enables; memory may ignore them on reads.
- **Store data**: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word unchanged.
- **Load data**: select the lane at addr[1:0], then zero- or sign-extend to 32 bits per d_uns.
- **Reset (rst=0)**
  - Takes effect at the edge in any state: FSM to IDLE, wait_cnt=0.
  - All outputs 0 after that edge, including m_req, every gnt, rvalid and err, all rdata, m_be and m_addr.
  - An aborted transaction produces no response. A late m_rvalid that arrives in IDLE is dropped.

## Timing
- A grant can only occur in IDLE, so the arbiter accepts one transaction at a time.
- Read, zero-wait memory (m_ready with m_req, m_rvalid one cycle later):
  - T0 gnt
  - T1 m_req
  - T2 m_rvalid
  - T3 rvalid
  - T4 IDLE; next grant earliest T4.
- Write: T0 gnt, T1 m_req/m_ready, T2 d_rvalid, T3 IDLE.
- Each memory stall cycle adds exactly one cycle of latency.
- m_* outputs stay stable from the first ISSUE cycle until m_ready.
- Requesters' address and data may change after gnt.

## Configuration
- Macro: MEM_PORT_ARB_FAIR_EN.
- Defined: starvation counter and MAX_WAIT fetch promotion as above.
- Undefined:
  - Strict data-over-fetch priority; wait_cnt is not built.
  - MAX_WAIT is ignored.
  - Fetch can starve under continuous d_req.

## Test plan
- Fetch only, if_addr=0x00400004, m_rdata=0x00500093 (zero-wait memory) → if_gnt T0, m_addr=0x00400004 at T1, if_rvalid with 0x00500093 at T3.
- Signed load byte, d_addr=0x10010003, d_uns=0, m_rdata=0x80FF0000 → m_be=4'b1000, d_rdata=0xFFFFFF80.
  - Same with d_uns=1 → 0x00000080.
- Store half, d_addr=0x10010002, d_wdata=0x1234ABCD → m_we=1, m_be=4'b1100, m_wdata=0xABCDABCD, d_rvalid two cycles after d_gnt.
- Misaligned word store at d_addr=0x10010001 → d_gnt and d_err in the same cycle; no m_req; FSM stays in IDLE.
- if_req and d_req held continuously, MAX_WAIT=2, fair build:
  - grant order is D, D, I, D, D, I.
  - Without MEM_PORT_ARB_FAIR_EN: D only.
- rst=0 during WAIT, m_rvalid arrives two cycles later → no if_rvalid or d_rvalid, all outputs 0, next request served normally.
